vdc_ramarbiter: RTL and testbench
=================================

Name: vdc_ramarbiter

Overview:
- Single-port arbiter for the VDC 8-bit video RAM, one access slot per enabled clock.
- Three requesters share the RAM: display fetch (character/attribute/bitmap), DRAM refresh (generated internally per raster line), and the CPU register engine (UA/DA reads and writes, block fill and block copy).
- Sits between the requesters and the vdcram instance and owns its we/addr/di pins.
- Routes read data back to the requester that owns the slot.

Parameters:
AW, 16, RAM address width
STARVE_LIMIT, 8, enabled cycles a pending CPU request may wait before it outranks refresh
RFSH_W, 4, width of the refresh-count input

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  clock enable; all state advances only when high
disp_req  in  1  display fetch request (level)
disp_addr  in  AW  display fetch address
disp_ack  out  1  display granted this slot (1-cycle pulse)
disp_rvalid  out  1  rdata holds display read data
cpu_req  in  1  CPU engine request (level)
cpu_we  in  1  CPU write
cpu_addr  in  AW  CPU address
cpu_di  in  8  CPU write data
cpu_ack  out  1  CPU granted this slot (1-cycle pulse)
cpu_rvalid  out  1  rdata holds CPU read data
rfsh_line  in  1  start-of-line pulse; reloads the refresh budget
rfsh_count  in  RFSH_W  refresh cycles per line (R36 low nibble)
rdata  out  8  read data returned to the slot owner
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_di  out  8  RAM write data
ram_do  in  8  RAM read data; valid one enabled cycle after the address is presented
stat_cpu_stall  out  16  CPU stall counter (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, owner=ARB_IDLE, rfsh_pend=0, rfsh_row=0, cpu_wait=0. Reset has priority over enable.
- Slot owner state: ARB_IDLE, ARB_DISP, ARB_RFSH, ARB_CPU. Re-evaluated on every enabled cycle. With enable low, all registers hold, and ack/rvalid hold 0.
- Priority on each enabled cycle:
  - disp_req wins, always.
  - Otherwise, if cpu_req is high and cpu_wait>=STARVE_LIMIT, CPU wins.
  - Otherwise, if rfsh_pend!=0, refresh wins.
  - Otherwise, if cpu_req is high, CPU wins.
  - Otherwise the slot goes to ARB_IDLE.
- On a grant, the following are registered in the same enabled cycle:
  - ram_addr = winner's address; ram_we = cpu_we only for a CPU grant, else 0; ram_di = cpu_di.
  - The matching ack pulses for exactly one enabled cycle.
  - Requesters hold their req and operands until ack. They may present a new request in the cycle after ack.
- Read return:
  - On the next enabled cycle, rdata is loaded from ram_do.
  - disp_rvalid is raised for a display slot. cpu_rvalid is raised for a CPU read slot only. CPU writes and refresh slots raise no rvalid.
  - Read latency is therefore 1 enabled cycle after ack. The pipeline accepts back-to-back grants.
- Refresh:
  - Refresh slots are dummy reads at ram_addr={0,rfsh_row}. rfsh_row is 8 bits and wraps 255->0. Each refresh slot decrements rfsh_pend.
  - rfsh_line reloads rfsh_pend=rfsh_count, discarding any unfinished budget.
  - If rfsh_line coincides with a refresh grant, the reload wins; the granted slot still executes.
- CPU starvation counter:
  - cpu_wait increments on each enabled cycle where cpu_req is high and cpu_ack is not given, saturating at STARVE_LIMIT.
  - It clears to 0 on cpu_ack.
  - Continuous display requests can still starve the CPU indefinitely (display is real-time). The CPU engine tolerates this.
- Reset mid-access: any pending rvalid is suppressed, no ack is issued in the reset cycle, and ram_we is forced 0.
- Address arithmetic: no translation here; 16k/64k shuffling is performed downstream.

Optional Feature:
- Macro VDC_ARB_STATS_EN.
- Defined: stat_cpu_stall counts enabled cycles where cpu_req is high without cpu_ack. It is 16 bits, saturates at 0xFFFF, and clears on reset.
- Undefined: stat_cpu_stall is tied to 0 and no counter logic is synthesised. Arbitration is identical in both builds.

Test Plan:
- CPU write 0x5A to 0x1234 with no other requests -> cpu_ack on the first enabled cycle, ram_we=1, ram_addr=0x1234, ram_di=0x5A; no cpu_rvalid.
- disp_req and cpu_req asserted together, display held for 3 cycles -> 3 disp_acks followed by cpu_ack on cycle 4; each disp_rvalid arrives 1 cycle after its ack with rdata=ram_do.
- rfsh_count=5, rfsh_line pulse, no other requests -> 5 refresh slots at addresses 0x0000..0x0004, rfsh_row=5 afterwards; with rfsh_row starting at 255 the address wraps to 0x0000.
- rfsh_count=15 with cpu_req held and STARVE_LIMIT=8 -> 8 refresh slots, then cpu_ack, then refresh resumes with the remaining 7.
- enable toggling 1-0-1 during a CPU read -> ack and rvalid occur only on enabled cycles; rdata is unchanged while enable=0.
- Reset asserted the cycle after a display ack -> no disp_rvalid and all outputs 0; with VDC_ARB_STATS_EN, stat_cpu_stall=0 after reset.

Source files
------------

// File: rtl/vdc_ramarbiter.sv
// Single-port video RAM arbiter: display fetch, DRAM refresh and CPU engine share one slot per enabled clock.
// Optional define VDC_ARB_STATS_EN adds a saturating CPU stall counter on stat_cpu_stall.
module vdc_ramarbiter #(
  parameter int AW           = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int RFSH_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              disp_req,
  input  logic [AW-1:0]     disp_addr,
  output logic              disp_ack,
  output logic              disp_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [7:0]        cpu_di,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  input  logic              rfsh_line,
  input  logic [RFSH_W-1:0] rfsh_count,
  output logic [7:0]        rdata,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [7:0]        ram_di,
  input  logic [7:0]        ram_do,
  output logic [15:0]       stat_cpu_stall
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_DISP, ARB_RFSH, ARB_CPU} owner_t;

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  owner_t              owner;
  owner_t              next_owner;
  logic [RFSH_W-1:0]   rfsh_pend;
  logic [7:0]          rfsh_row;
  logic [WAIT_W-1:0]   cpu_wait;
  logic                cpu_starved;
  logic                cpu_stalled;

  assign cpu_starved = (cpu_wait >= WAIT_W'(STARVE_LIMIT));

  // NOTE: next_owner gets a default before the priority chain so no path leaves it unassigned (no latch).
  always_comb begin
    next_owner = ARB_IDLE;
    if (disp_req)                    next_owner = ARB_DISP;
    else if (cpu_req && cpu_starved) next_owner = ARB_CPU;
    else if (rfsh_pend != '0)        next_owner = ARB_RFSH;
    else if (cpu_req)                next_owner = ARB_CPU;
  end

  assign cpu_stalled = cpu_req && (next_owner != ARB_CPU);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= ARB_IDLE;
      rfsh_pend   <= '0;
      rfsh_row    <= '0;
      cpu_wait    <= '0;
      disp_ack    <= 1'b0;
      cpu_ack     <= 1'b0;
      disp_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
      rdata       <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_di      <= '0;
    end else if (enable) begin
      // Return data for the slot granted on the previous enabled cycle.
      disp_rvalid <= (owner == ARB_DISP);
      cpu_rvalid  <= (owner == ARB_CPU) && !ram_we;
      if (owner != ARB_IDLE) rdata <= ram_do;

      owner    <= next_owner;
      disp_ack <= (next_owner == ARB_DISP);
      cpu_ack  <= (next_owner == ARB_CPU);
      ram_we   <= (next_owner == ARB_CPU) && cpu_we;

      unique case (next_owner)
        ARB_DISP: begin ram_addr <= disp_addr;       ram_di <= cpu_di; end
        ARB_RFSH: begin ram_addr <= AW'(rfsh_row);   ram_di <= cpu_di; end
        ARB_CPU:  begin ram_addr <= cpu_addr;        ram_di <= cpu_di; end
        default:  ;
      endcase

      // A line pulse replaces the budget outright, even on a refresh slot.
      if (rfsh_line)                    rfsh_pend <= rfsh_count;
      else if (next_owner == ARB_RFSH)  rfsh_pend <= rfsh_pend - RFSH_W'(1);
      if (next_owner == ARB_RFSH)       rfsh_row  <= rfsh_row + 8'd1;

      if (next_owner == ARB_CPU)           cpu_wait <= '0;
      else if (cpu_stalled && !cpu_starved) cpu_wait <= cpu_wait + WAIT_W'(1);
    end else begin
      disp_ack    <= 1'b0;
      cpu_ack     <= 1'b0;
      disp_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
    end
  end

`ifdef VDC_ARB_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)                                         stall_cnt <= '0;
    else if (enable && cpu_stalled && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

  assign stat_cpu_stall = stall_cnt;
`else
  assign stat_cpu_stall = '0;
`endif

endmodule

// File: tb/tb_vdc_ramarbiter.sv
// Self-checking bench for vdc_ramarbiter: slot-level reference model compared every cycle plus directed literal checks.
// Honours VDC_ARB_STATS_EN for the expected stall counter.
module tb_vdc_ramarbiter;

  localparam int AW = 16;
  localparam int LIMIT = 8;
  localparam int K_IDLE = 0, K_DISP = 1, K_RFSH = 2, K_CPU = 3;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        disp_req, cpu_req, cpu_we, rfsh_line;
  logic [15:0] disp_addr, cpu_addr;
  logic [7:0]  cpu_di, ram_do, rdata, ram_di;
  logic [3:0]  rfsh_count;
  logic        disp_ack, disp_rvalid, cpu_ack, cpu_rvalid, ram_we;
  logic [15:0] ram_addr, stat_cpu_stall;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  vdc_ramarbiter #(.AW(AW), .STARVE_LIMIT(LIMIT), .RFSH_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rvalid(disp_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .rfsh_line(rfsh_line), .rfsh_count(rfsh_count), .rdata(rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
    .stat_cpu_stall(stat_cpu_stall)
  );

  // Bench RAM contents: each byte is a fixed hash of its address.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign ram_do = mem_byte(ram_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the last slot as a record and applies the priority rules.
  int          m_kind, m_pend, m_row, m_wait, m_stall, win;
  bit          m_write;
  logic        e_disp_ack, e_cpu_ack, e_disp_rvalid, e_cpu_rvalid, e_we;
  logic [15:0] e_addr;
  logic [7:0]  e_di, e_rdata;

  always @(posedge clk) begin
    if (reset) begin
      m_kind = K_IDLE; m_write = 0; m_pend = 0; m_row = 0; m_wait = 0; m_stall = 0;
      e_disp_ack = 0; e_cpu_ack = 0; e_disp_rvalid = 0; e_cpu_rvalid = 0;
      e_we = 0; e_addr = 0; e_di = 0; e_rdata = 0;
    end else if (enable) begin
      e_disp_rvalid = (m_kind == K_DISP);
      e_cpu_rvalid  = (m_kind == K_CPU) && !m_write;
      if (m_kind != K_IDLE) e_rdata = mem_byte(e_addr);

      if (disp_req)                      win = K_DISP;
      else if (cpu_req && m_wait >= LIMIT) win = K_CPU;
      else if (m_pend > 0)               win = K_RFSH;
      else if (cpu_req)                  win = K_CPU;
      else                               win = K_IDLE;

      e_disp_ack = (win == K_DISP);
      e_cpu_ack  = (win == K_CPU);
      e_we       = (win == K_CPU) && cpu_we;
      if (win == K_DISP) e_addr = disp_addr;
      if (win == K_RFSH) e_addr = 16'(m_row);
      if (win == K_CPU)  e_addr = cpu_addr;
      if (win != K_IDLE) e_di = cpu_di;
      m_kind  = win;
      m_write = e_we;

      if (win == K_RFSH) m_row = (m_row + 1) % 256;
      if (rfsh_line)          m_pend = int'(rfsh_count);
      else if (win == K_RFSH) m_pend = m_pend - 1;

      if (cpu_req && win != K_CPU) begin
        if (m_wait < LIMIT) m_wait++;
        if (m_stall < 65535) m_stall++;
      end
      if (win == K_CPU) m_wait = 0;
    end else begin
      e_disp_ack = 0; e_cpu_ack = 0; e_disp_rvalid = 0; e_cpu_rvalid = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("disp_ack",    32'(disp_ack),    32'(e_disp_ack));
      check("cpu_ack",     32'(cpu_ack),     32'(e_cpu_ack));
      check("disp_rvalid", 32'(disp_rvalid), 32'(e_disp_rvalid));
      check("cpu_rvalid",  32'(cpu_rvalid),  32'(e_cpu_rvalid));
      check("ram_we",      32'(ram_we),      32'(e_we));
      check("ram_addr",    32'(ram_addr),    32'(e_addr));
      check("ram_di",      32'(ram_di),      32'(e_di));
      check("rdata",       32'(rdata),       32'(e_rdata));
`ifdef VDC_ARB_STATS_EN
      check("stat_cpu_stall", 32'(stat_cpu_stall), 32'(m_stall));
`else
      check("stat_cpu_stall", 32'(stat_cpu_stall), 32'd0);
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic line_pulse(input logic [3:0] cnt);
    rfsh_count = cnt; rfsh_line = 1'b1;
    tick();
    rfsh_line = 1'b0;
  endtask

  initial begin
    int k, n;
    reset = 1'b1; enable = 1'b1;
    disp_req = 0; disp_addr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_di = 0;
    rfsh_line = 0; rfsh_count = 0;
    tick();
    started = 1'b1;
    tick();
    check("reset_ram_addr", 32'(ram_addr), 32'h0);
    check("reset_stat", 32'(stat_cpu_stall), 32'h0);
    reset = 1'b0;
    tick();

    // CPU write alone: granted on the first enabled cycle, no read return.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_di = 8'h5A;
    tick();
    check("wr_ack", 32'(cpu_ack), 32'h1);
    check("wr_we", 32'(ram_we), 32'h1);
    check("wr_addr", 32'(ram_addr), 32'h1234);
    check("wr_di", 32'(ram_di), 32'h5A);
    cpu_req = 0; cpu_we = 0;
    tick();
    check("wr_no_rvalid", 32'(cpu_rvalid), 32'h0);

    // Display held three cycles beats a pending CPU read.
    disp_req = 1; disp_addr = 16'h0100; cpu_req = 1; cpu_addr = 16'h2222;
    tick();
    check("d1_ack", 32'(disp_ack), 32'h1);
    disp_addr = 16'h0101;
    tick();
    check("d1_rvalid", 32'(disp_rvalid), 32'h1);
    check("d1_rdata", 32'(rdata), 32'hA4);
    disp_addr = 16'h0102;
    tick();
    check("d3_ack", 32'(disp_ack), 32'h1);
    disp_req = 0;
    tick();
    check("c4_ack", 32'(cpu_ack), 32'h1);
    check("d3_rdata", 32'(rdata), 32'hA6);
    cpu_req = 0;
    tick();
    check("c4_rvalid", 32'(cpu_rvalid), 32'h1);
    check("c4_rdata", 32'(rdata), 32'hA5);

    // Five refresh slots from row 0.
    line_pulse(4'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rfsh_addr", 32'(ram_addr), 32'(i));
    end
    tick(2);

    // Starvation: 15 refreshes pending, CPU waiting wins after 8 refresh slots.
    line_pulse(4'd15);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3333;
    k = 0;
    while (!cpu_ack && k < 40) begin tick(); k++; end
    check("starve_cycles", 32'(k), 32'd9);
    check("starve_addr", 32'(ram_addr), 32'h3333);
    cpu_req = 0;
    tick(7);
    check("rfsh_resume_last", 32'(ram_addr), 32'h0013);
    tick(2);
    check("rfsh_done_hold", 32'(ram_addr), 32'h0013);

    // Reload while a refresh slot is granted: the new budget replaces the old one.
    line_pulse(4'd3);
    tick();
    line_pulse(4'd2);
    tick(4);

    // Drive the row to 253, then check the 255 -> 0 wrap.
    while (m_row != 253) begin
      n = (253 - m_row) > 15 ? 15 : 253 - m_row;
      line_pulse(4'(n));
      tick(n + 1);
    end
    line_pulse(4'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wrap_addr", 32'(ram_addr), 32'((253 + i) % 256));
    end
    tick(2);

    // Enable toggles 1-0-1 during a CPU read.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4455;
    tick();
    check("en_ack", 32'(cpu_ack), 32'h1);
    cpu_req = 0; enable = 0;
    tick();
    check("en_off_ack", 32'(cpu_ack), 32'h0);
    check("en_off_rvalid", 32'(cpu_rvalid), 32'h0);
    enable = 1;
    tick();
    check("en_rvalid", 32'(cpu_rvalid), 32'h1);
    check("en_rdata", 32'(rdata), 32'hB4);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0001; cpu_di = 8'hC3; enable = 0;
    tick();
    check("en_off_no_grant", 32'(cpu_ack), 32'h0);
    enable = 1;
    tick();
    check("en_on_grant", 32'(cpu_ack), 32'h1);
    cpu_req = 0; cpu_we = 0;
    tick();

    // CPU stalled behind display so the stall counter moves.
    disp_req = 1; disp_addr = 16'h0200; cpu_req = 1; cpu_addr = 16'h0300;
    tick(4);
    disp_req = 0;
    tick();
    cpu_req = 0;
    tick();

    // Reset the cycle after a display ack.
    disp_req = 1; disp_addr = 16'h0777;
    tick();
    check("rst_disp_ack", 32'(disp_ack), 32'h1);
    disp_req = 0; reset = 1;
    tick();
    check("rst_no_rvalid", 32'(disp_rvalid), 32'h0);
    check("rst_addr", 32'(ram_addr), 32'h0);
    check("rst_stat", 32'(stat_cpu_stall), 32'h0);
    reset = 0;
    tick();

    // Reset right after a CPU write grant forces ram_we low.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0ABC; cpu_di = 8'h11;
    tick();
    check("rstw_we_before", 32'(ram_we), 32'h1);
    cpu_req = 0; cpu_we = 0; reset = 1;
    tick();
    check("rstw_we_after", 32'(ram_we), 32'h0);
    reset = 0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
